if_id_buffer: RTL and testbench
===============================

// Module: if_id_buffer
// PURPOSE
//  IF/ID pipeline buffer between instruction fetch and decode.
//  - Accepts fetched {pc, instr} over a valid/ready handshake.
//  - Pre-decodes the opcode into the 2-bit immediate-type select consumed by the
//    immediate extender (0=I, 1=S, 2=SB, 3=U).
//  - Presents instr[31:7] plus the select to decode through a 2-entry skid buffer,
//    so a decode stall never drops a fetched word.
// PARAMETERS
//  WIDTH     32  instruction width (fixed 32 for RV32I)
//  PC_WIDTH  32  program-counter width
// PORTS
//  clk           in   1         single clock, rising edge
//  rstN          in   1         synchronous, active-low reset
//  flush         in   1         kill all buffered entries (branch taken)
//  in_valid      in   1         fetch word valid
//  in_ready      out  1         buffer can accept this cycle
//  in_pc         in   PC_WIDTH  fetch PC
//  in_instr      in   WIDTH     fetched instruction
//  out_valid     out  1         decode entry valid
//  out_ready     in   1         decode consumes entry this cycle
//  out_pc        out  PC_WIDTH  PC of head entry
//  out_instr     out  WIDTH     head instruction; [31:7] feeds extender 'in'
//  out_imm_sel   out  2         extender selector for head entry
//  out_has_imm   out  1         0 for R-type (select value then 0, don't-use)
// BEHAVIOUR
//  - Reset (rstN=0 at clk edge): out_valid=0, skid valid=0, out_pc/out_instr=0, out_imm_sel=0,
//    out_has_imm=0; in_ready=0 while rstN=0, 1 on first cycle after release.
//  - Storage: main reg (drives outputs) + skid reg. in_ready = rstN & !skid_valid
//    (registered state only; no comb path from out_ready to in_ready).
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Main empty or Pop: main loads skid if skid_valid, else the accepted word.
//  - Main full & !Pop & Accept: word goes to skid; in_ready drops next cycle.
//  - Pop with skid_valid and a new Accept is impossible (in_ready=0).
//  - Latency: Accept at cycle N -> out_valid at N+1. Throughput: 1 word/cycle with out_ready=1.
//  - Ordering strictly FIFO. Output fields stable while out_valid & !out_ready.
//  - Flush: both valids cleared at edge; a same-cycle Accept is dropped; Pop is
//    ignored. in_ready=1 on next cycle. Flush has priority over everything but reset.
//  - Reset mid-operation: both entries discarded, no output pulse.
//  - Pre-decode on in_instr[6:0], stored with the entry:
//      0000011 lw, 0010011 op-imm, 1100111 jalr -> sel 0, has_imm 1
//      0100011 sw -> sel 1 | 1100011 branch -> sel 2 | 0110111 lui, 0010111 auipc -> sel 3
//      0110011 R-type -> sel 0, has_imm 0 | any other opcode (incl. jal) -> sel 0, has_imm 0
// CONFIGURATION
//  - IFID_ILLEGAL_TRAP_EN defined: extra output out_illegal (1 bit, reset 0) set for opcodes
//    not in the table above, stored per entry, aligned with out_valid.
//  - Undefined: port absent; illegal opcodes pass silently as has_imm=0.
// STRUCTURE
//  - Shared package riscv_pkg: opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE,
//    OP_BRANCH, OP_LUI, OP_AUIPC, OP_REG) and enum imm_sel_e {IMM_I, IMM_S, IMM_SB, IMM_U}
//    matching the extender encoding.
//  - Packed struct ifid_entry_t {pc, instr, imm_sel, has_imm[, illegal]} in riscv_pkg.
//  - One sub-module: imm_sel_decode (combinational opcode -> imm_sel/has_imm/illegal),
//    instantiated once on the input side.
// TESTING
//  1. Reset held 3 cycles, release -> out_valid=0, in_ready=0 during reset, 1 on the first cycle after release.
//  2. Stream 0x00A00093 (addi), 0x00112223 (sw), 0x00208463 (beq), 0x123450B7 (lui),
//     out_ready=1 -> one cycle later each, in order, sel 0/1/2/3, has_imm=1.
//  3. out_ready=0, push 3 words -> two accepted, in_ready=0 after the 2nd;
//     raise out_ready -> words emerge in order, no loss/duplication.
//  4. Skid full + flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle word never appears.
//  5. 0x002081B3 (add) -> has_imm=0; 0x0000006F (jal) -> has_imm=0, out_illegal=1 with macro.
//  6. Random valid/ready throttling vs scoreboard, 10k words -> exact FIFO match.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the IF/ID buffer: opcodes, immediate-type
// encoding and the buffered entry layout. IFID_ILLEGAL_TRAP_EN adds an illegal flag per entry.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Encoding must match the immediate extender's select input.
  typedef enum logic [1:0] {
    IMM_I  = 2'd0,
    IMM_S  = 2'd1,
    IMM_SB = 2'd2,
    IMM_U  = 2'd3
  } imm_sel_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] instr;
    imm_sel_e        imm_sel;
    logic            has_imm;
`ifdef IFID_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } ifid_entry_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode pre-decode: immediate-type select and has-immediate flag.
// With IFID_ILLEGAL_TRAP_EN an illegal-opcode flag is also produced.
module imm_sel_decode
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_sel_e   o_imm_sel,
  output logic       o_has_imm
`ifdef IFID_ILLEGAL_TRAP_EN
  ,
  output logic       o_illegal
`endif
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    o_imm_sel = IMM_I;
    o_has_imm = 1'b1;
`ifdef IFID_ILLEGAL_TRAP_EN
    o_illegal = 1'b0;
`endif
    case (i_opcode)
      OP_LOAD, OP_IMM, OP_JALR: o_imm_sel = IMM_I;
      OP_STORE:                 o_imm_sel = IMM_S;
      OP_BRANCH:                o_imm_sel = IMM_SB;
      OP_LUI, OP_AUIPC:         o_imm_sel = IMM_U;
      OP_REG:                   o_has_imm = 1'b0;
      default: begin
        // Unknown opcodes (jal included) carry no extender immediate.
        o_has_imm = 1'b0;
`ifdef IFID_ILLEGAL_TRAP_EN
        o_illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: valid/ready input, opcode pre-decode, 2-entry skid
// buffer toward decode. IFID_ILLEGAL_TRAP_EN adds the out_illegal output.
module if_id_buffer
  import riscv_pkg::*;
#(
  parameter int WIDTH    = XLEN,
  parameter int PC_WIDTH = PC_W
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0]    in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0]    out_instr,
  output logic [1:0]          out_imm_sel,
  output logic                out_has_imm
`ifdef IFID_ILLEGAL_TRAP_EN
  ,
  output logic                out_illegal
`endif
);

  imm_sel_e    w_imm_sel;
  logic        w_has_imm;
  ifid_entry_t w_entry;
  logic        w_accept;
  logic        w_pop;

  ifid_entry_t r_main;
  ifid_entry_t r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;

`ifdef IFID_ILLEGAL_TRAP_EN
  logic        w_illegal;
`endif

  imm_sel_decode u_imm_sel_decode (
    .i_opcode  (in_instr[6:0]),
    .o_imm_sel (w_imm_sel),
    .o_has_imm (w_has_imm)
`ifdef IFID_ILLEGAL_TRAP_EN
    ,
    .o_illegal (w_illegal)
`endif
  );

  always_comb begin
    w_entry         = '0;
    w_entry.pc      = in_pc;
    w_entry.instr   = in_instr;
    w_entry.imm_sel = w_imm_sel;
    w_entry.has_imm = w_has_imm;
`ifdef IFID_ILLEGAL_TRAP_EN
    w_entry.illegal = w_illegal;
`endif
  end

  // Ready depends only on registered state, so decode's out_ready never reaches fetch combinationally.
  assign in_ready = rstN & ~r_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_pop    = r_main_valid & out_ready;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  // NOTE: both entries are reset (not just their valids) so outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_pop) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_entry;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_entry;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid   = r_main_valid;
  assign out_pc      = r_main.pc;
  assign out_instr   = r_main.instr;
  assign out_imm_sel = r_main.imm_sel;
  assign out_has_imm = r_main.has_imm;
`ifdef IFID_ILLEGAL_TRAP_EN
  assign out_illegal = r_main.illegal;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: stimulus pushes expected entries, a
// negedge monitor pops and compares each consumed output. Honors IFID_ILLEGAL_TRAP_EN.
module tb_if_id_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  sel;
    logic        has;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  out_imm_sel;
  logic        out_has_imm;
`ifdef IFID_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  exp_t q[$];
  exp_t vec[11];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_pops = 0;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk         (clk),
    .rstN        (rstN),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_imm_sel (out_imm_sel),
    .out_has_imm (out_has_imm)
`ifdef IFID_ILLEGAL_TRAP_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [127:0] obs();
    logic ill;
`ifdef IFID_ILLEGAL_TRAP_EN
    ill = out_illegal;
`else
    ill = 1'b0;
`endif
    return {60'd0, out_pc, out_instr, out_imm_sel, out_has_imm, ill};
  endfunction

  function automatic logic [127:0] exp_vec(input exp_t e);
    logic ill;
`ifdef IFID_ILLEGAL_TRAP_EN
    ill = e.ill;
`else
    ill = 1'b0;
`endif
    return {60'd0, e.pc, e.instr, e.sel, e.has, ill};
  endfunction

  // Monitor: consumes and compares entries; also checks hold stability under stall.
  logic         hold = 1'b0;
  logic [127:0] held = '0;
  always @(negedge clk) begin
    if (rstN && !flush) begin
      if (hold) check("hold_stable", {59'd0, out_valid, obs()}, {59'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", {127'd0, out_valid}, 128'd0);
        end else begin
          check("sb_entry", obs(), exp_vec(q.pop_front()));
          n_pops++;
        end
      end
      hold <= out_valid && !out_ready;
      held <= obs();
    end else begin
      hold <= 1'b0;
    end
  end

  // One clock of stimulus: drive, account the handshake at negedge, advance.
  task automatic cycle(input bit v, input exp_t e, input bit rdy, input bit fl, output bit acc);
    in_valid  = v;
    in_pc     = e.pc;
    in_instr  = e.instr;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    acc = in_valid && in_ready && rstN;
    if (fl) q.delete();
    else if (acc) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins,
                              input logic [1:0] sel, input logic has, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = ins; e.sel = sel; e.has = has; e.ill = ill;
    return e;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit   acc;
    int   p0;
    int   k;
    exp_t idle;
    exp_t cur;

    vec[0]  = mk(32'h0000_1000, 32'h00A00093, 2'd0, 1'b1, 1'b0); // addi
    vec[1]  = mk(32'h0000_1004, 32'h00112223, 2'd1, 1'b1, 1'b0); // sw
    vec[2]  = mk(32'h0000_1008, 32'h00208463, 2'd2, 1'b1, 1'b0); // beq
    vec[3]  = mk(32'h0000_100C, 32'h123450B7, 2'd3, 1'b1, 1'b0); // lui
    vec[4]  = mk(32'h0000_2000, 32'h0000A103, 2'd0, 1'b1, 1'b0); // lw
    vec[5]  = mk(32'h0000_2004, 32'h000080E7, 2'd0, 1'b1, 1'b0); // jalr
    vec[6]  = mk(32'h0000_2008, 32'h00000117, 2'd3, 1'b1, 1'b0); // auipc
    vec[7]  = mk(32'h0000_3000, 32'h002081B3, 2'd0, 1'b0, 1'b0); // add
    vec[8]  = mk(32'h0000_3004, 32'h0000006F, 2'd0, 1'b0, 1'b1); // jal
    vec[9]  = mk(32'h0000_3008, 32'hFFFFFFFF, 2'd0, 1'b0, 1'b1); // bad opcode
    vec[10] = mk(32'h0000_300C, 32'h0000000F, 2'd0, 1'b0, 1'b1); // fence
    idle    = mk(32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

    // Test 1: reset held, then released
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", {127'd0, in_ready}, 128'd0);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("post_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("post_rst_fields", obs(), 128'd0);
    @(posedge clk);
    #1;

    // Test 2: back-to-back stream, 1-cycle latency, full throughput
    p0 = n_pops;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vec[i], 1'b1, 1'b0, acc);
      check("t2_accept", {127'd0, acc}, 128'd1);
    end
    cycle(1'b0, idle, 1'b1, 1'b0, acc);
    check("t2_latency_pops", 128'(n_pops - p0), 128'd4);

    // Test 3: stall fills main + skid, third word held off
    p0 = n_pops;
    cycle(1'b1, vec[4], 1'b0, 1'b0, acc);
    check("t3_acc_a", {127'd0, acc}, 128'd1);
    cycle(1'b1, vec[5], 1'b0, 1'b0, acc);
    check("t3_acc_b", {127'd0, acc}, 128'd1);
    cycle(1'b1, vec[6], 1'b0, 1'b0, acc);
    check("t3_full_blocks", {127'd0, acc}, 128'd0);
    k = 0;
    do begin
      cycle(1'b1, vec[6], 1'b1, 1'b0, acc);
      k++;
    end while (!acc && k < 10);
    check("t3_c_accepted", {127'd0, acc}, 128'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1, 1'b0, acc);
    check("t3_pops", 128'(n_pops - p0), 128'd3);
    check("t3_drained", 128'(q.size()), 128'd0);

    // Test 4: flush with skid full and a word offered the same cycle
    p0 = n_pops;
    cycle(1'b1, vec[0], 1'b0, 1'b0, acc);
    cycle(1'b1, vec[1], 1'b0, 1'b0, acc);
    cycle(1'b1, vec[2], 1'b1, 1'b1, acc);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    check("t4_out_valid", {127'd0, out_valid}, 128'd0);
    check("t4_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1, 1'b0, acc);
    check("t4_no_pop", 128'(n_pops - p0), 128'd0);

    // Test 5: no-immediate and illegal opcodes
    p0 = n_pops;
    for (int i = 7; i < 11; i++) cycle(1'b1, vec[i], 1'b1, 1'b0, acc);
    for (int i = 0; i < 2; i++) cycle(1'b0, idle, 1'b1, 1'b0, acc);
    check("t5_pops", 128'(n_pops - p0), 128'd4);

    // Test 6: random throttling, 10k words
    p0 = n_pops;
    cur = vec[$urandom_range(0, 10)];
    cur.pc = $urandom();
    for (int w = 0; w < 10000; ) begin
      cycle($urandom_range(0, 99) < 70, cur, $urandom_range(0, 99) < 65, 1'b0, acc);
      if (acc) begin
        w++;
        cur = vec[$urandom_range(0, 10)];
        cur.pc = $urandom();
      end
    end
    k = 0;
    while (q.size() != 0 && k < 200) begin
      cycle(1'b0, idle, 1'b1, 1'b0, acc);
      k++;
    end
    check("t6_drained", 128'(q.size()), 128'd0);
    check("t6_pop_total", 128'(n_pops - p0), 128'd10000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
